// File: rtl/mul_accum_store.sv
// Multi-row accumulator for the big-number multiplier: sums offset partial-product rows
// into a wide accumulator, then streams the result out LSW-first and zeroes it as it goes.
module mul_accum_store #(
    parameter int REGISTER_SIZE   = 32,
    parameter int NUM_BITS_STORED = 2048,
    parameter int DESIRED_SIZE    = 2080
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic [REGISTER_SIZE-1:0]                      low_in,
    input  logic [REGISTER_SIZE-1:0]                      high_in,
    input  logic [$clog2(DESIRED_SIZE/REGISTER_SIZE):0]   start_padding,
    input  logic                                          valid_in,
    input  logic                                          last_in,
    input  logic                                          final_in,
    output logic                                          ready_out,
    output logic [REGISTER_SIZE-1:0]                      data_out,
    output logic                                          valid_out,
    output logic                                          last_out,
    output logic                                          overflow_out,
    input  logic                                          ready_in
);

    localparam int ACC_WORDS = DESIRED_SIZE / REGISTER_SIZE;
    localparam int ROW_WORDS = NUM_BITS_STORED / REGISTER_SIZE;
    localparam int PW        = $clog2(ACC_WORDS) + 1;
    localparam int AW        = (ACC_WORDS > 1) ? $clog2(ACC_WORDS) : 1;
    localparam int RW        = $clog2(ACC_WORDS + ROW_WORDS + 1);
    localparam int KW        = (RW > PW) ? RW : PW;
    localparam int SW        = REGISTER_SIZE + 2;

    localparam logic [KW-1:0] K_END  = KW'(ACC_WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(ACC_WORDS - 1);

    typedef enum logic [2:0] {CLEAR, IDLE, ACCUM, FLUSH, CARRY, OUTPUT} state_e;

    state_e                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [REGISTER_SIZE-1:0] ph_q, ph_d;
    logic [1:0]               c_q, c_d;
    logic                     fin_q, fin_d;
    logic                     ovf_q, ovf_d;
    logic [REGISTER_SIZE-1:0] acc_q [ACC_WORDS];

    logic                     wrEn;
    logic [AW-1:0]            wrAddr;
    logic [REGISTER_SIZE-1:0] wrData;
    logic [KW-1:0]            kEff, kEffNext;
    logic [REGISTER_SIZE-1:0] lowEff, phEff, accRd;
    logic [1:0]               cEff;
    logic                     inRange, beat, addStep;
    logic [SW-1:0]            sum;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= CLEAR;
            k_q     <= '0;
            ph_q    <= '0;
            c_q     <= '0;
            fin_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ph_q    <= ph_d;
            c_q     <= c_d;
            fin_q   <= fin_d;
            ovf_q   <= ovf_d;
        end
    end

    // The array needs no reset: CLEAR zeroes every word before anything reads it.
    always_ff @(posedge clk_in) begin
        if (wrEn) begin
            acc_q[wrAddr] <= wrData;
        end
    end

    always_comb begin
        beat    = ((state_q == IDLE) || (state_q == ACCUM)) && valid_in;
        kEff    = (state_q == IDLE) ? KW'(start_padding) : k_q;
        phEff   = (state_q == IDLE) ? '0 : ph_q;
        cEff    = (state_q == IDLE) ? 2'd0 : c_q;
        lowEff  = beat ? low_in : '0;
        inRange = (kEff < K_END);
        accRd   = inRange ? acc_q[kEff[AW-1:0]] : '0;
        sum     = SW'(accRd) + SW'(lowEff) + SW'(phEff) + SW'(cEff);
        kEffNext = inRange ? kEff + 1'b1 : kEff;
        addStep = beat || (state_q == FLUSH) ||
                  ((state_q == CARRY) && (c_q != 2'd0) && (k_q < K_END));

        state_d = state_q;
        k_d     = k_q;
        ph_d    = ph_q;
        c_d     = c_q;
        fin_d   = fin_q;
        ovf_d   = ovf_q;
        wrEn    = 1'b0;
        wrAddr  = k_q[AW-1:0];
        wrData  = '0;

        case (state_q)
            CLEAR: begin
                wrEn = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            IDLE, ACCUM: begin
                if (valid_in) begin
                    ph_d    = high_in;
                    state_d = ACCUM;
                    if (last_in) begin
                        fin_d   = final_in;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                ph_d    = '0;
                state_d = CARRY;
            end
            CARRY: begin
                if ((c_q == 2'd0) || (k_q >= K_END)) begin
                    if (c_q != 2'd0) begin
                        ovf_d = 1'b1;
                    end
                    state_d = fin_q ? OUTPUT : IDLE;
                    k_d     = '0;
                end
            end
            OUTPUT: begin
                if (ready_in) begin
                    wrEn = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = IDLE;
                        k_d     = '0;
                        fin_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase

        // Words that land past the top are dropped; a nonzero drop means truncation.
        if (addStep) begin
            c_d = sum[SW-1:REGISTER_SIZE];
            k_d = kEffNext;
            if (inRange) begin
                wrEn   = 1'b1;
                wrAddr = kEff[AW-1:0];
                wrData = sum[REGISTER_SIZE-1:0];
            end else if (sum[REGISTER_SIZE-1:0] != '0) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        ready_out = (state_q == IDLE) || (state_q == ACCUM);
        valid_out = (state_q == OUTPUT);
        last_out  = (state_q == OUTPUT) && (k_q == K_LAST);
        data_out  = (state_q == OUTPUT) ? acc_q[k_q[AW-1:0]] : '0;
    end

    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_mul_accum_store.sv
// Scoreboard bench for mul_accum_store: a big-integer model predicts each product's
// output words, which are queued and compared as the DUT streams them out.
module tb_mul_accum_store;

    localparam int R   = 8;
    localparam int ACC = 4;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic [R-1:0] low_in, high_in;
    logic [2:0]   start_padding;
    logic         valid_in, last_in, final_in, ready_in;
    logic         ready_out, valid_out, last_out, overflow_out;
    logic [R-1:0] data_out;

    typedef struct packed {
        logic         ovf;
        logic         last;
        logic [R-1:0] data;
    } expWord_t;

    expWord_t     sb[$];
    expWord_t     head;
    int           vectors = 0;
    int           miscompares = 0;
    int           hsCount = 0;
    logic [127:0] accModel;
    logic         ovfModel;

    mul_accum_store #(
        .REGISTER_SIZE  (8),
        .NUM_BITS_STORED(16),
        .DESIRED_SIZE   (32)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .low_in       (low_in),
        .high_in      (high_in),
        .start_padding(start_padding),
        .valid_in     (valid_in),
        .last_in      (last_in),
        .final_in     (final_in),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .last_out     (last_out),
        .overflow_out (overflow_out),
        .ready_in     (ready_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Output words are checked every cycle they are valid, so stalls verify stability too.
    always @(negedge clk_in) begin
        if (!rst_in && valid_out) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedWord", 32'(sb.size()), 1);
            end else begin
                head = sb[0];
                checkOutput($sformatf("data[%0d]", hsCount), 32'(data_out), 32'(head.data));
                checkOutput($sformatf("last[%0d]", hsCount), 32'(last_out), 32'(head.last));
                checkOutput($sformatf("ovf[%0d]", hsCount), 32'(overflow_out), 32'(head.ovf));
                if (ready_in) begin
                    void'(sb.pop_front());
                    hsCount++;
                end
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "Ready"}, 32'(ready_out), 0);
        checkOutput({tag, "Valid"}, 32'(valid_out), 0);
        checkOutput({tag, "Last"}, 32'(last_out), 0);
        checkOutput({tag, "Ovf"}, 32'(overflow_out), 0);
        checkOutput({tag, "Data"}, 32'(data_out), 0);
    endtask

    // Called right after reset release, one time unit past a rising edge.
    task automatic waitClear();
        checkOutput("relReady", 32'(ready_out), 0);
        for (int cyc = 1; cyc <= ACC; cyc++) begin
            @(posedge clk_in);
            #1;
            checkOutput($sformatf("clearReady%0d", cyc), 32'(ready_out), 32'(cyc == ACC));
        end
    endtask

    task automatic driveBeat(input logic [R-1:0] lo, input logic [R-1:0] hi, input logic [2:0] off,
                             input logic last, input logic fin);
        int n = 0;
        low_in = lo;
        high_in = hi;
        start_padding = off;
        last_in = last;
        final_in = fin;
        valid_in = 1'b1;
        @(negedge clk_in);
        while (!ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (!ready_out) checkOutput("readyWait", 32'(ready_out), 1);
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        last_in = 1'b0;
        final_in = 1'b0;
    endtask

    // Second beat carries a different offset, which the DUT must ignore mid-row.
    task automatic applyStimulus(input int off, input logic [R-1:0] lo0, input logic [R-1:0] hi0,
                                 input logic [R-1:0] lo1, input logic [R-1:0] hi1, input logic fin);
        logic [127:0] row, tot;
        row = 128'(lo0) + (128'(hi0) << R) + (128'(lo1) << R) + (128'(hi1) << (2 * R));
        tot = accModel + (row << (off * R));
        if (tot[127:32] != '0) ovfModel = 1'b1;
        accModel = {96'b0, tot[31:0]};
        driveBeat(lo0, hi0, 3'(off), 1'b0, 1'b0);
        driveBeat(lo1, hi1, 3'(off + 1), 1'b1, fin);
        if (fin) begin
            for (int w = 0; w < ACC; w++) begin
                sb.push_back('{ovf: ovfModel, last: 1'(w == ACC - 1), data: accModel[w*R +: R]});
            end
            accModel = '0;
            ovfModel = 1'b0;
        end
    endtask

    task automatic drain(input int stallWord, input int stallLen);
        int cyc = 0;
        int left = stallLen;
        hsCount = 0;
        while (sb.size() > 0 && cyc < 200) begin
            @(posedge clk_in);
            #1;
            if (hsCount == stallWord && left > 0) begin
                ready_in = 1'b0;
                left--;
            end else begin
                ready_in = 1'b1;
            end
            cyc++;
        end
        ready_in = 1'b1;
        checkOutput("drainDone", 32'(sb.size()), 0);
        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("validAfter", 32'(valid_out), 0);
        checkOutput("ovfAfter", 32'(overflow_out), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        low_in = '0;
        high_in = '0;
        start_padding = '0;
        valid_in = 1'b0;
        last_in = 1'b0;
        final_in = 1'b0;
        ready_in = 1'b1;
        accModel = '0;
        ovfModel = 1'b0;

        repeat (2) @(posedge clk_in);
        #1;
        checkIdleOutputs("rst");
        rst_in = 1'b0;
        waitClear();

        applyStimulus(0, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        drain(-1, 0);

        applyStimulus(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        applyStimulus(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        drain(-1, 0);

        applyStimulus(2, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        drain(-1, 0);

        applyStimulus(0, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        drain(1, 3);

        driveBeat(8'h11, 8'h22, 3'd0, 1'b0, 1'b0);
        #2;
        rst_in = 1'b1;
        #1;
        checkIdleOutputs("asyncRst");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        waitClear();

        applyStimulus(0, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        drain(-1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_accum_store.md
Name: mul_accum_store

Overview:
- Multi-row accumulator for the big-number multiplier datapath.
- Each incoming row is a stream of (low, high) partial-product chunk pairs from a REGISTER_SIZE x NUM_BITS_STORED multiply. The row is added at a per-row word offset into a DESIRED_SIZE-bit accumulator, with full carry propagation.
- After the final row, the accumulated result streams out LSW-first under ready/valid backpressure. The accumulator is zeroed as it is read.
- Successor to the overwrite-only store: accumulates rows instead of overwriting, has downstream backpressure, and reports overflow.

Parameters:
- REGISTER_SIZE, 32, chunk width in bits.
- NUM_BITS_STORED, 2048, bits per input row; ROW_WORDS = NUM_BITS_STORED/REGISTER_SIZE chunk pairs per row.
- DESIRED_SIZE, 2080, accumulator width; ACC_WORDS = DESIRED_SIZE/REGISTER_SIZE; must be an exact multiple of REGISTER_SIZE.

Ports:
- clk_in, input, 1, clock.
- rst_in, input, 1, reset, asynchronous, active-high.
- low_in, input, REGISTER_SIZE, low chunk of the current pair.
- high_in, input, REGISTER_SIZE, high chunk of the current pair.
- start_padding, input, $clog2(ACC_WORDS)+1, row word offset; sampled on the first beat of a row.
- valid_in, input, 1, pair valid.
- last_in, input, 1, marks the final pair of a row.
- final_in, input, 1, qualified with last_in; this row is the last one of the product.
- ready_out, output, 1, block accepts a pair this cycle.
- data_out, output, REGISTER_SIZE, result word.
- valid_out, output, 1, data_out valid.
- last_out, output, 1, marks the top result word.
- overflow_out, output, 1, sticky; result was truncated modulo 2^DESIRED_SIZE.
- ready_in, input, 1, downstream accepts data_out.

Behaviour:
- Storage: ACC_WORDS x REGISTER_SIZE array.
- Internal state: word pointer k, pending-high register ph, carry register c (2 bits; the 3-operand sum plus carry never carries more than 2).
- Async reset: state goes to CLEAR, pointers to 0. ready_out, valid_out, last_out and overflow_out are 0 immediately. data_out is 0.
- States:
  - CLEAR: write 0 to word k, k++ each cycle; after word ACC_WORDS-1 go to IDLE. Takes exactly ACC_WORDS cycles; ready_out=0 throughout.
  - IDLE: ready_out=1. On valid_in, latch k=start_padding, then treat the beat exactly as in ACCUM with ph=0, c=0. The next state is ACCUM, or FLUSH if last_in is set on this beat.
  - ACCUM: ready_out=1. On each valid_in:
    - compute {c', s} = acc[k] + low_in + ph + c;
    - write s to word k if k < ACC_WORDS;
    - set ph=high_in, c=c', k++;
    - if last_in, latch final_in and go to FLUSH.
    - No valid_in: hold.
  - FLUSH: ready_out=0. Write acc[k] + ph + c, set ph=0, k++, then go to CARRY.
  - CARRY: ready_out=0. While c != 0 and k < ACC_WORDS: acc[k] += c, k++. When c==0 or k==ACC_WORDS: go to OUTPUT if final was latched, else IDLE.
  - OUTPUT: rd pointer starts at 0.
    - valid_out=1 and data_out=acc[rd] combinationally; last_out=(rd==ACC_WORDS-1).
    - On valid_out && ready_in: write 0 to word rd, rd++.
    - Handshake on the last word: go to IDLE and clear overflow_out in the same edge.
    - With ready_in=0, data_out and last_out hold stable.
- Truncation: any write with k >= ACC_WORDS is dropped. overflow_out is set if the dropped value is nonzero, or if c != 0 when k reaches ACC_WORDS in CARRY.
- Throughput: 1 pair/cycle in ACCUM.
- Per-row overhead: 1 FLUSH cycle plus up to (ACC_WORDS - k) CARRY cycles.
- Output: ACC_WORDS cycles at full ready_in.
- valid_in while ready_out=0 is ignored, not buffered.
- A mid-row start_padding change is ignored.
- A zero-length row is not supported; a row is at least 1 pair.
- Reset during any state aborts the operation and re-runs CLEAR.

Test Plan:
All scenarios use REGISTER_SIZE=8, NUM_BITS_STORED=16, DESIRED_SIZE=32 (ROW_WORDS=2, ACC_WORDS=4).
1. Reset release -> ready_out=0 for exactly 4 cycles, then 1. All outputs are 0 during reset.
2. One row, offset 0, pairs (low=11,high=22) then (33,44) with last+final -> output 11,55,44,00. last_out on the 4th word; overflow_out=0.
3. Two rows, offset 0, each pair (FF,FF),(FF,FF), second row final -> output FE,FD,01,02 (0x0201FDFE). Carry ripple exercised.
4. One row, offset 2, pairs (01,02),(03,04) final -> output 00,00,01,05 with overflow_out=1 while valid. overflow_out=0 after the last handshake.
5. Backpressure: in scenario 2, hold ready_in=0 for 3 cycles at word 1 -> data_out stays 55 with valid_out=1. No word is skipped or duplicated. A subsequent product starts from a zeroed accumulator.
6. Assert rst_in asynchronously mid-ACCUM -> outputs drop to 0 before the next edge, CLEAR repeats for 4 cycles, then scenario 2 yields the exact scenario-2 result.
